// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles every handshake and bus signal around the memory port arbiter:
//   the instruction-fetch request port (if_*), the load/store data port (d_*),
//   the single-ported memory macro port (mem_*), and the busy status flag.
//
//   Modports
//     slave  : the arbiter's view. It receives requests and memory read data,
//              and it drives grants, responses, memory strobes and busy.
//     master : the surrounding system's view. This is the fetch unit, the
//              load/store unit and the memory macro taken together.
//
//   Signals
//     if_req / if_addr                    fetch request and byte address
//     if_gnt / if_rvalid / if_rdata       fetch accept pulse, response pulse, word
//     d_req / d_we / d_addr / d_wdata     data request, store flag, address, data
//     d_gnt / d_rvalid / d_rdata          data accept pulse, response pulse, load data
//     mem_en / mem_we / mem_addr          memory strobe, write enable, address
//     mem_wdata / mem_rdata               memory write data, read data
//     busy                                arbiter has a transaction in flight
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        busy;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported 32-bit memory between instruction fetch (IF) and
//   the load/store data port (D). Only one transaction is outstanding at a time.
//   D wins contested arbitration. A streak counter counts consecutive contested
//   D grants, and once it reaches MAX_STREAK the next contested grant goes to IF
//   so that fetch cannot starve.
//
//   Transaction flow: IDLE (grant) -> ISSUE (mem_en) -> WAIT (latency) -> RESP.
//   If the grant is in cycle T, mem_en is high in T+1 and rvalid is high in
//   T+2+MEM_LATENCY. The earliest next grant is in T+3+MEM_LATENCY.
//
//   Parameters
//     MEM_LATENCY  cycles from the mem_en cycle to valid mem_rdata (1..15)
//     MAX_STREAK   contested D grants before IF is forced (1..15)
//
//   Ports
//     clk  rising-edge clock
//     rst  asynchronous active-high reset. It returns the arbiter to IDLE,
//          clears every output and abandons any in-flight transaction.
//     bus  mem_port_arbiter_if.slave, which carries all request, response
//          and memory signals.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter int MAX_STREAK  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_port_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  state_t      state_q, state_d;
  logic        owner_d_q;      // 1: the transaction belongs to D, 0: it belongs to IF
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  lat_cnt_q;
  logic [3:0]  streak_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;

  logic        gnt_if;
  logic        gnt_d;
  logic        force_if;
  logic        resp_take;

  // Streak increment that saturates at the starvation threshold.
  function automatic logic [3:0] streak_sat_inc(input logic [3:0] s);
    if (s >= STREAK_MAX) begin
      return STREAK_MAX;
    end
    return s + 4'd1;
  endfunction

  // Stores return zero on the data port. Loads and fetches return the memory word.
  function automatic logic [31:0] resp_data(input logic is_store,
                                            input logic [31:0] rdata);
    return is_store ? 32'h0 : rdata;
  endfunction

  assign force_if  = bus.if_req && (streak_q == STREAK_MAX);
  assign resp_take = (state_q == WAIT) && (lat_cnt_q == 4'd0);

  // Next-state and grant logic. Grants exist only in IDLE. They are masked
  // while rst is high, so that no grant is visible during reset even though
  // the state already reads IDLE.
  always_comb begin
    state_d = state_q;
    gnt_if  = 1'b0;
    gnt_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst) begin
          if (bus.d_req && !force_if) begin
            gnt_d = 1'b1;
          end else if (bus.if_req) begin
            gnt_if = 1'b1;
          end
          if (gnt_d || gnt_if) begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (lat_cnt_q == 4'd0) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage boundary: the grant decision is latched into the transaction
  // registers, and the state, latency counter and starvation streak advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_d_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      lat_cnt_q <= 4'd0;
      streak_q  <= 4'd0;
    end else begin
      state_q <= state_d;

      if (gnt_d) begin
        owner_d_q <= 1'b1;
        we_q      <= bus.d_we;
        addr_q    <= bus.d_addr;
        wdata_q   <= bus.d_wdata;
        if (bus.if_req) begin
          streak_q <= streak_sat_inc(streak_q);
        end
      end else if (gnt_if) begin
        owner_d_q <= 1'b0;
        we_q      <= 1'b0;
        addr_q    <= bus.if_addr;
        streak_q  <= 4'd0;
      end

      // The counter is loaded during ISSUE, so WAIT lasts MEM_LATENCY cycles
      // and its last cycle coincides with valid mem_rdata.
      if (state_q == ISSUE) begin
        lat_cnt_q <= LAT_LOAD;
      end else if ((state_q == WAIT) && (lat_cnt_q != 4'd0)) begin
        lat_cnt_q <= lat_cnt_q - 4'd1;
      end
    end
  end

  // Stage boundary: the memory response is captured into the owner's data
  // register at the end of WAIT, so the new value appears together with rvalid
  // in RESP. The other port's register keeps its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else if (resp_take) begin
      if (owner_d_q) begin
        d_rdata_q <= resp_data(we_q, bus.mem_rdata);
      end else begin
        if_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.if_gnt    = gnt_if;
  assign bus.d_gnt     = gnt_d;
  assign bus.if_rvalid = (state_q == RESP) && !owner_d_q;
  assign bus.d_rvalid  = (state_q == RESP) &&  owner_d_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = (state_q == ISSUE);
  assign bus.mem_we    = (state_q == ISSUE) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
